// File: rtl/csa_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder built around a single 4-bit carry-select block.
// One nibble is summed per clock, LSB nibble first. The inter-nibble carry is
// held in a register and drives the block's select input on the next cycle.

// 4-bit carry-select block: both carry cases are precomputed and sel picks one.
module carry_select_adder_4_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic [3:0] sum_c,
    output logic       cout_c
);

    logic [4:0] sum0;
    logic [4:0] sum1;

    // Carry-in 0 and carry-in 1 results, selected by the incoming carry.
    always_comb begin
        sum0            = 5'({1'b0, a}) + 5'({1'b0, b});
        sum1            = sum0 + 5'd1;
        {cout_c, sum_c} = sel ? sum1 : sum0;
    end

endmodule

module csa_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    // Reject widths that cannot be split into whole nibbles.
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("csa_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   partial;
    logic               carry_r;
    logic [IDX_W-1:0]   idx;

    logic [3:0]         blk_sum;
    logic               blk_cout;
    logic [IDX_W+1:0]   nib_base;
    logic [WIDTH-1:0]   result_c;
    logic               last_nib;

    carry_select_adder_4_block u_blk (
        .a      (a_sh[3:0]),
        .b      (b_sh[3:0]),
        .sel    (carry_r),
        .sum_c  (blk_sum),
        .cout_c (blk_cout)
    );

    // Partial result with the current nibble merged in; becomes sum on the last nibble.
    always_comb begin
        nib_base             = {idx, 2'b00};
        last_nib             = (idx == IDX_W'(NIB - 1));
        result_c             = partial;
        result_c[nib_base +: 4] = blk_sum;
    end

    // Control FSM and datapath registers; sum/cout update only on the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            partial <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_r <= cin;
                        idx     <= '0;
                        partial <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    partial <= result_c;
                    carry_r <= blk_cout;
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    idx     <= idx + IDX_W'(1);
                    if (last_nib) begin
                        sum   <= result_c;
                        cout  <= blk_cout;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
